axi_grid_xni_buf: RTL and testbench

- Buffered, parametrised grid network interface.
- Successor to the direct pass-through grid NI, covering one grid channel (instantiated once per AW/W/B/AR/R).
- Each hop gets DEPTH-entry elastic buffering, plus local ejection of flits addressed to NI_ID.
- Local injection is round-robin arbitrated onto the grid output, with burst locking on last.

---
 rtl/axi_grid_xni_buf.sv | 271 +++++++++++++++++++++++++++
 tb/tb_axi_grid_xni_buf.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_grid_xni_buf.sv
// axi_grid_xni_buf: buffered network interface for one grid channel.
// Grid-in flits go into the THRU FIFO. A head addressed to NI_ID is ejected
// locally, and any other head is forwarded. Local injections go into the
// INJ FIFO. THRU and INJ heads are round-robin arbitrated onto grid-out.
// A grant stays locked until the burst's last flit has been handed off.
module axi_grid_xni_buf #(
   parameter int unsigned      ID_W   = 4,
   parameter int unsigned      CHAN_W = 64,
   parameter int unsigned      DEPTH  = 4,
   parameter logic [ID_W-1:0]  NI_ID  = '0
) (
   input  logic              clk_i,
   input  logic              arst_ni,
   // grid input
   input  logic [ID_W-1:0]   in_did_i,
   input  logic [ID_W-1:0]   in_sid_i,
   input  logic [CHAN_W-1:0] in_chan_i,
   input  logic              in_last_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   // local injection
   input  logic [ID_W-1:0]   inj_did_i,
   input  logic [CHAN_W-1:0] inj_chan_i,
   input  logic              inj_last_i,
   input  logic              inj_valid_i,
   output logic              inj_ready_o,
   // grid output
   output logic [ID_W-1:0]   out_did_o,
   output logic [ID_W-1:0]   out_sid_o,
   output logic [CHAN_W-1:0] out_chan_o,
   output logic              out_last_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   // local ejection
   output logic [ID_W-1:0]   ej_sid_o,
   output logic [CHAN_W-1:0] ej_chan_o,
   output logic              ej_last_o,
   output logic              ej_valid_o,
   input  logic              ej_ready_i
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ENT_W = 2 * ID_W + CHAN_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // grant source encoding
   localparam logic SRC_THRU = 1'b0;
   localparam logic SRC_INJ  = 1'b1;

   // ------------------------------------------------------------------
   // THRU FIFO state
   // ------------------------------------------------------------------
   logic [ENT_W-1:0] r_thru_mem [DEPTH];
   logic [PTR_W-1:0] r_thru_wr_ptr;
   logic [PTR_W-1:0] r_thru_rd_ptr;
   logic [CNT_W-1:0] r_thru_cnt;

   logic              w_thru_full;
   logic              w_thru_empty;
   logic              w_thru_push;
   logic              w_thru_pop;
   logic [ENT_W-1:0]  w_thru_head;
   logic [ID_W-1:0]   w_thru_did;
   logic [ID_W-1:0]   w_thru_sid;
   logic [CHAN_W-1:0] w_thru_chan;
   logic              w_thru_last;

   // ------------------------------------------------------------------
   // INJ FIFO state
   // ------------------------------------------------------------------
   logic [ENT_W-1:0] r_inj_mem [DEPTH];
   logic [PTR_W-1:0] r_inj_wr_ptr;
   logic [PTR_W-1:0] r_inj_rd_ptr;
   logic [CNT_W-1:0] r_inj_cnt;

   logic              w_inj_full;
   logic              w_inj_empty;
   logic              w_inj_push;
   logic              w_inj_pop;
   logic [ENT_W-1:0]  w_inj_head;
   logic [ID_W-1:0]   w_inj_did;
   logic [ID_W-1:0]   w_inj_sid;
   logic [CHAN_W-1:0] w_inj_chan;
   logic              w_inj_last;

   // ------------------------------------------------------------------
   // Arbiter state
   // ------------------------------------------------------------------
   logic r_rr;        // preferred source when both request
   logic r_lock;      // burst in progress
   logic r_lock_src;  // source owning the burst

   logic              w_thru_local;
   logic              w_thru_req;
   logic              w_inj_req;
   logic              w_grant;
   logic              w_out_valid;
   logic              w_out_fire;
   logic              w_ej_valid;
   logic              w_ej_fire;
   logic [ID_W-1:0]   w_out_did;
   logic [ID_W-1:0]   w_out_sid;
   logic [CHAN_W-1:0] w_out_chan;
   logic              w_out_last;

   // ------------------------------------------------------------------
   // FIFO status and head decode
   // ------------------------------------------------------------------
   assign w_thru_full  = (r_thru_cnt == FULL_CNT);
   assign w_thru_empty = (r_thru_cnt == '0);
   assign w_inj_full   = (r_inj_cnt == FULL_CNT);
   assign w_inj_empty  = (r_inj_cnt == '0);

   assign in_ready_o  = ~w_thru_full;
   assign inj_ready_o = ~w_inj_full;

   assign w_thru_push = in_valid_i & ~w_thru_full;
   assign w_inj_push  = inj_valid_i & ~w_inj_full;

   assign w_thru_head = r_thru_mem[r_thru_rd_ptr];
   assign w_thru_did  = w_thru_head[ENT_W-1 -: ID_W];
   assign w_thru_sid  = w_thru_head[ENT_W-ID_W-1 -: ID_W];
   assign w_thru_chan = w_thru_head[CHAN_W:1];
   assign w_thru_last = w_thru_head[0];

   assign w_inj_head  = r_inj_mem[r_inj_rd_ptr];
   assign w_inj_did   = w_inj_head[ENT_W-1 -: ID_W];
   assign w_inj_sid   = w_inj_head[ENT_W-ID_W-1 -: ID_W];
   assign w_inj_chan  = w_inj_head[CHAN_W:1];
   assign w_inj_last  = w_inj_head[0];

   // ------------------------------------------------------------------
   // Routing: a THRU head for this node is ejected and never arbitrated
   // ------------------------------------------------------------------
   assign w_thru_local = (w_thru_did == NI_ID);
   assign w_ej_valid   = ~w_thru_empty & w_thru_local;
   assign w_thru_req   = ~w_thru_empty & ~w_thru_local;
   assign w_inj_req    = ~w_inj_empty;
   assign w_ej_fire    = w_ej_valid & ej_ready_i;

   // grant selection: lock first, then RR when contended, else sole requester
   always_comb begin
      w_grant     = SRC_THRU;
      w_out_valid = 1'b0;
      if (r_lock) begin
         // a locked burst waits for its own source even when that source is empty
         w_grant     = r_lock_src;
         w_out_valid = (r_lock_src == SRC_INJ) ? w_inj_req : w_thru_req;
      end else if (w_thru_req && w_inj_req) begin
         w_grant     = r_rr;
         w_out_valid = 1'b1;
      end else if (w_inj_req) begin
         w_grant     = SRC_INJ;
         w_out_valid = 1'b1;
      end else if (w_thru_req) begin
         w_grant     = SRC_THRU;
         w_out_valid = 1'b1;
      end
   end

   // output mux of the granted head
   always_comb begin
      if (w_grant == SRC_INJ) begin
         w_out_did  = w_inj_did;
         w_out_sid  = w_inj_sid;
         w_out_chan = w_inj_chan;
         w_out_last = w_inj_last;
      end else begin
         w_out_did  = w_thru_did;
         w_out_sid  = w_thru_sid;
         w_out_chan = w_thru_chan;
         w_out_last = w_thru_last;
      end
   end

   assign w_out_fire = w_out_valid & out_ready_i;

   // each FIFO pops only on its own handshake
   assign w_thru_pop = (w_out_fire & (w_grant == SRC_THRU)) | w_ej_fire;
   assign w_inj_pop  = w_out_fire & (w_grant == SRC_INJ);

   // data outputs are held at zero while the matching valid is low
   assign out_valid_o = w_out_valid;
   assign out_did_o   = w_out_valid ? w_out_did  : '0;
   assign out_sid_o   = w_out_valid ? w_out_sid  : '0;
   assign out_chan_o  = w_out_valid ? w_out_chan : '0;
   assign out_last_o  = w_out_valid & w_out_last;

   assign ej_valid_o = w_ej_valid;
   assign ej_sid_o   = w_ej_valid ? w_thru_sid  : '0;
   assign ej_chan_o  = w_ej_valid ? w_thru_chan : '0;
   assign ej_last_o  = w_ej_valid & w_thru_last;

   // ------------------------------------------------------------------
   // Storage writes (payload needs no reset; occupancy is tracked separately)
   // ------------------------------------------------------------------
   // THRU storage write
   always_ff @(posedge clk_i) begin
      if (w_thru_push) begin
         r_thru_mem[r_thru_wr_ptr] <= {in_did_i, in_sid_i, in_chan_i, in_last_i};
      end
   end

   // INJ storage write; the source ID is always this node
   always_ff @(posedge clk_i) begin
      if (w_inj_push) begin
         r_inj_mem[r_inj_wr_ptr] <= {inj_did_i, NI_ID, inj_chan_i, inj_last_i};
      end
   end

   // THRU pointers and occupancy
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_thru_wr_ptr <= '0;
         r_thru_rd_ptr <= '0;
         r_thru_cnt    <= '0;
      end else begin
         if (w_thru_push) begin
            r_thru_wr_ptr <= r_thru_wr_ptr + 1'b1;
         end
         if (w_thru_pop) begin
            r_thru_rd_ptr <= r_thru_rd_ptr + 1'b1;
         end
         case ({w_thru_push, w_thru_pop})
            2'b10:   r_thru_cnt <= r_thru_cnt + 1'b1;
            2'b01:   r_thru_cnt <= r_thru_cnt - 1'b1;
            default: r_thru_cnt <= r_thru_cnt;
         endcase
      end
   end

   // INJ pointers and occupancy
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_inj_wr_ptr <= '0;
         r_inj_rd_ptr <= '0;
         r_inj_cnt    <= '0;
      end else begin
         if (w_inj_push) begin
            r_inj_wr_ptr <= r_inj_wr_ptr + 1'b1;
         end
         if (w_inj_pop) begin
            r_inj_rd_ptr <= r_inj_rd_ptr + 1'b1;
         end
         case ({w_inj_push, w_inj_pop})
            2'b10:   r_inj_cnt <= r_inj_cnt + 1'b1;
            2'b01:   r_inj_cnt <= r_inj_cnt - 1'b1;
            default: r_inj_cnt <= r_inj_cnt;
         endcase
      end
   end

   // arbiter: RR advances and lock clears on last; non-last locks the grant
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_rr       <= SRC_THRU;
         r_lock     <= 1'b0;
         r_lock_src <= SRC_THRU;
      end else if (w_out_fire) begin
         if (w_out_last) begin
            r_lock <= 1'b0;
            r_rr   <= ~w_grant;
         end else begin
            r_lock     <= 1'b1;
            r_lock_src <= w_grant;
         end
      end
   end

endmodule

// File: tb/tb_axi_grid_xni_buf.sv
// Directed bench for axi_grid_xni_buf with NI_ID=2 and DEPTH=4.
module tb_axi_grid_xni_buf;

   localparam int unsigned ID_W   = 4;
   localparam int unsigned CHAN_W = 64;

   logic              clk;
   logic              arst_ni;
   logic [ID_W-1:0]   in_did, in_sid;
   logic [CHAN_W-1:0] in_chan;
   logic              in_last, in_valid, in_ready;
   logic [ID_W-1:0]   inj_did;
   logic [CHAN_W-1:0] inj_chan;
   logic              inj_last, inj_valid, inj_ready;
   logic [ID_W-1:0]   out_did, out_sid;
   logic [CHAN_W-1:0] out_chan;
   logic              out_last, out_valid, out_ready;
   logic [ID_W-1:0]   ej_sid;
   logic [CHAN_W-1:0] ej_chan;
   logic              ej_last, ej_valid, ej_ready;

   int n_chk  = 0;
   int n_pass = 0;

   axi_grid_xni_buf #(
      .ID_W   (ID_W),
      .CHAN_W (CHAN_W),
      .DEPTH  (4),
      .NI_ID  (4'd2)
   ) dut (
      .clk_i       (clk),
      .arst_ni     (arst_ni),
      .in_did_i    (in_did),
      .in_sid_i    (in_sid),
      .in_chan_i   (in_chan),
      .in_last_i   (in_last),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .inj_did_i   (inj_did),
      .inj_chan_i  (inj_chan),
      .inj_last_i  (inj_last),
      .inj_valid_i (inj_valid),
      .inj_ready_o (inj_ready),
      .out_did_o   (out_did),
      .out_sid_o   (out_sid),
      .out_chan_o  (out_chan),
      .out_last_o  (out_last),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .ej_sid_o    (ej_sid),
      .ej_chan_o   (ej_chan),
      .ej_last_o   (ej_last),
      .ej_valid_o  (ej_valid),
      .ej_ready_i  (ej_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] e;
      arst_ni  = 1'b0;
      in_did   = '0; in_sid = '0; in_chan = '0; in_last = 1'b0; in_valid = 1'b0;
      inj_did  = '0; inj_chan = '0; inj_last = 1'b0; inj_valid = 1'b0;
      out_ready = 1'b0; ej_ready = 1'b0;

      // ---- reset ----
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ej_valid",  ej_valid,  0);
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_inj_ready", inj_ready, 1);
      chk("rst_out_chan",  out_chan,  0);
      arst_ni = 1'b1;
      tick();
      chk("idle_out_valid", out_valid, 0);
      chk("idle_ej_valid",  ej_valid,  0);

      // ---- single forwarded flit ----
      in_did = 4'd5; in_sid = 4'd7; in_chan = 64'hA5; in_last = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("fwd_valid", out_valid, 1);
      chk("fwd_did",   out_did,   5);
      chk("fwd_sid",   out_sid,   7);
      chk("fwd_chan",  out_chan,  64'hA5);
      chk("fwd_last",  out_last,  1);
      chk("fwd_no_ej", ej_valid,  0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("fwd_drained", out_valid, 0);

      // ---- single ejected flit ----
      in_did = 4'd2; in_sid = 4'd3; in_chan = 64'hA5; in_last = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("ej_valid",   ej_valid,  1);
      chk("ej_chan",    ej_chan,   64'hA5);
      chk("ej_sid",     ej_sid,    3);
      chk("ej_last",    ej_last,   1);
      chk("ej_no_out",  out_valid, 0);
      ej_ready = 1'b1;
      tick();
      ej_ready = 1'b0;
      chk("ej_drained", ej_valid, 0);

      // ---- fill THRU to DEPTH ----
      for (int i = 0; i < 4; i++) begin
         chk("fill_ready", in_ready, 1);
         in_did = 4'd5; in_sid = 4'd7; in_chan = 64'(16 + i); in_last = 1'b1; in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      chk("full_ready", in_ready, 0);
      chk("full_head",  out_chan, 64'h10);
      // push attempt and pop in the same cycle while full
      in_chan = 64'h99; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("fullpp_ready", in_ready, 1);
      chk("fullpp_head",  out_chan, 64'h11);
      tick();
      chk("drain_12", out_chan, 64'h12);
      tick();
      chk("drain_13", out_chan, 64'h13);
      tick();
      chk("refused_not_stored", out_valid, 0);

      // ---- order across pointer wrap, streaming 10 flits ----
      for (int k = 0; k <= 10; k++) begin
         if (k >= 1) begin
            e = 64'(256 + k - 1);
            chk("wrap_valid", out_valid, 1);
            chk("wrap_chan",  out_chan,  e);
         end
         in_did = 4'd5; in_sid = 4'd7; in_chan = 64'(256 + k); in_last = 1'b1;
         in_valid = (k < 10);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("wrap_empty", out_valid, 0);

      // ---- round robin (fresh reset puts RR on THRU) ----
      arst_ni = 1'b0;
      #1;
      arst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_did = 4'd5; in_sid = 4'd7; in_chan = 64'(512 + i); in_last = 1'b1; in_valid = 1'b1;
         inj_did = 4'd9; inj_chan = 64'(768 + i); inj_last = 1'b1; inj_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0; inj_valid = 1'b0;
      out_ready = 1'b1;
      chk("rr0_sid", out_sid, 7);  chk("rr0_chan", out_chan, 64'h200);
      tick();
      chk("rr1_sid", out_sid, 2);  chk("rr1_chan", out_chan, 64'h300);
      chk("rr1_did", out_did, 9);
      tick();
      chk("rr2_sid", out_sid, 7);  chk("rr2_chan", out_chan, 64'h201);
      tick();
      chk("rr3_sid", out_sid, 2);  chk("rr3_chan", out_chan, 64'h301);
      tick();
      chk("rr4_sid", out_sid, 7);  chk("rr4_chan", out_chan, 64'h202);
      tick();
      chk("rr5_sid", out_sid, 2);  chk("rr5_chan", out_chan, 64'h302);
      tick();
      chk("rr_empty", out_valid, 0);
      out_ready = 1'b0;

      // ---- burst lock (RR now points at THRU) ----
      in_did = 4'd5; in_sid = 4'd7; in_chan = 64'h400; in_last = 1'b1; in_valid = 1'b1;
      inj_did = 4'd9; inj_chan = 64'h500; inj_last = 1'b0; inj_valid = 1'b1;
      tick();
      in_chan = 64'h401; inj_chan = 64'h501;
      tick();
      in_valid = 1'b0; inj_valid = 1'b0;
      out_ready = 1'b1;
      chk("bl_a_chan", out_chan, 64'h400);
      tick();
      chk("bl_b_chan", out_chan, 64'h500);
      chk("bl_b_last", out_last, 0);
      tick();
      chk("bl_c_chan", out_chan, 64'h501);
      tick();
      chk("bl_gap_valid", out_valid, 0);
      inj_chan = 64'h502; inj_last = 1'b1; inj_valid = 1'b1;
      tick();
      inj_valid = 1'b0;
      chk("bl_e_chan", out_chan, 64'h502);
      chk("bl_e_last", out_last, 1);
      tick();
      chk("bl_f_chan", out_chan, 64'h401);
      chk("bl_f_sid",  out_sid,  7);
      tick();
      chk("bl_empty", out_valid, 0);
      out_ready = 1'b0;

      // ---- mid-operation reset with INJ lock held ----
      inj_did = 4'd9; inj_chan = 64'h600; inj_last = 1'b0; inj_valid = 1'b1;
      tick();
      inj_chan = 64'h601;
      tick();
      inj_valid = 1'b0;
      out_ready = 1'b1;
      chk("mr_first", out_chan, 64'h600);
      tick();
      out_ready = 1'b0;
      in_did = 4'd5; in_sid = 4'd7; in_chan = 64'h700; in_last = 1'b1; in_valid = 1'b1;
      tick();
      in_chan = 64'h701;
      tick();
      in_valid = 1'b0;
      chk("mr_locked_chan", out_chan, 64'h601);
      arst_ni = 1'b0;
      #1;
      chk("mr_rst_out_valid", out_valid, 0);
      chk("mr_rst_ej_valid",  ej_valid,  0);
      chk("mr_rst_in_ready",  in_ready,  1);
      chk("mr_rst_inj_ready", inj_ready, 1);
      chk("mr_rst_out_chan",  out_chan,  0);
      tick();
      arst_ni = 1'b1;
      chk("mr_post_empty", out_valid, 0);
      in_did = 4'd5; in_sid = 4'd4; in_chan = 64'h800; in_last = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("mr_new_valid", out_valid, 1);
      chk("mr_new_chan",  out_chan,  64'h800);
      chk("mr_new_sid",   out_sid,   4);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("mr_new_drained", out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
